fcmplt_rr_scheduler: RTL

- Shares one 15-bit FloPoCo less-than comparator (an fcmplt instance) among NREQ independent requesters.
- Format: exc[14:13], sign[12], exp[11:6], frac[5:0].
- Requesters arbitrate round-robin. Operands and results are registered, and results return on a single valid/ready response channel tagged with the requester id.
- Sits between HLS-generated compare call sites and the shared comparator core.

---
 rtl/fcmplt_rr_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fcmplt_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fcmplt        : 15-bit FloPoCo-format less-than comparator (combinational).
//                 Format exc[14:13] sign[12] exp[11:6] frac[5:0];
//                 exc 00=zero, 01=normal, 10=inf, 11=NaN.
//   clk         : present for interface compatibility; no pipeline stages.
//   X, Y        : operands.
//   XltY        : X < Y (forced 0 when unordered).
//   unordered   : either operand is NaN.
//
// fcmplt_rr_scheduler : shares one fcmplt among NREQ requesters with
//                 round-robin arbitration and a registered valid/ready
//                 response channel tagged with the requester id.
//   clk, rst          : clock, async active-high reset.
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero).
//   req_x, req_y      : packed operands, requester i at [15*i +: 15].
//   rsp_valid/ready   : response handshake.
//   rsp_id            : owner of the response.
//   rsp_xlty          : registered X < Y.
//   rsp_unordered     : registered NaN flag.
//   done_cnt          : completed responses, wraps at 16 bits.
// ---------------------------------------------------------------------------
module fcmplt #(
  parameter int ID = 0
) (
  input  logic        clk,
  input  logic [14:0] X,
  input  logic [14:0] Y,
  output logic        XltY,
  output logic        unordered
);
  // Purely combinational core; these only keep the interface complete.
  logic        unused_clk;
  logic [31:0] unused_id;
  assign unused_clk = clk;
  assign unused_id  = ID;

  logic [13:0] mag_x, mag_y;
  logic        neg_x, neg_y, lt_raw;

  // Ordering key: exc above exp above frac gives zero < normal < inf.
  // Zeros collapse to magnitude 0 and drop their sign so +0 == -0.
  assign mag_x = (X[14:13] == 2'b00) ? 14'd0 : {X[14:13], X[11:0]};
  assign mag_y = (Y[14:13] == 2'b00) ? 14'd0 : {Y[14:13], Y[11:0]};
  assign neg_x = X[12] & (|mag_x);
  assign neg_y = Y[12] & (|mag_y);

  always_comb begin
    if (neg_x != neg_y) lt_raw = neg_x;
    else if (neg_x)     lt_raw = (mag_x > mag_y);
    else                lt_raw = (mag_x < mag_y);
  end

  assign unordered = (X[14:13] == 2'b11) | (Y[14:13] == 2'b11);
  assign XltY      = lt_raw & ~unordered;
endmodule

module fcmplt_rr_scheduler #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*15-1:0] req_x,
  input  logic [NREQ*15-1:0] req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_xlty,
  output logic               rsp_unordered,
  output logic [15:0]        done_cnt
);
  typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [14:0]     x_q, x_d, y_q, y_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_xlty_q, rsp_xlty_d;
  logic            rsp_unordered_q, rsp_unordered_d;
  logic [15:0]     done_cnt_q, done_cnt_d;

  logic            cmp_lt, cmp_un;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;

  fcmplt u_cmp (
    .clk       (clk),
    .X         (x_q),
    .Y         (y_q),
    .XltY      (cmp_lt),
    .unordered (cmp_un)
  );

  // Round-robin search starting at rr_ptr. Walking offsets from high to low
  // lets the nearest valid requester win the final overwrite.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    x_d             = x_q;
    y_d             = y_q;
    id_d            = id_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_xlty_d      = rsp_xlty_q;
    rsp_unordered_d = rsp_unordered_q;
    done_cnt_d      = done_cnt_q;
    req_ready       = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          x_d      = req_x[15*gnt_idx +: 15];
          y_d      = req_y[15*gnt_idx +: 15];
          id_d     = gnt_idx;
          // Explicit wrap so non-power-of-two NREQ never points past the end.
          rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d  = CMP;
        end
      end
      CMP: begin
        rsp_xlty_d      = cmp_lt;
        rsp_unordered_d = cmp_un;
        rsp_id_d        = id_q;
        rsp_valid_d     = 1'b1;
        state_d         = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      x_q             <= '0;
      y_q             <= '0;
      id_q            <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_xlty_q      <= 1'b0;
      rsp_unordered_q <= 1'b0;
      done_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      x_q             <= x_d;
      y_q             <= y_d;
      id_q            <= id_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_xlty_q      <= rsp_xlty_d;
      rsp_unordered_q <= rsp_unordered_d;
      done_cnt_q      <= done_cnt_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_xlty      = rsp_xlty_q;
  assign rsp_unordered = rsp_unordered_q;
  assign done_cnt      = done_cnt_q;
endmodule
